serial_rx: RTL

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/serial_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial-line definitions.
// 8N1 framing constants and receiver states.
package serial_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for async inputs.
// Width and reset value are parameters.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver, mid-bit sampling.
// Break or bad stop parks in RECOVER until line idles.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CTR_SIZE-1:0] HALF_M1 =
    CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] FULL_M1 =
    CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t           state, state_n;
  logic [CTR_SIZE-1:0] ctr, ctr_n;
  logic [2:0]          bit_idx, bit_n;
  logic [7:0]          shreg, sh_n;
  logic [7:0]          data_n;
  logic                nd_n, fe_n;
  logic                rx_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (IDLE_LVL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  // Next state, counters, shift register and output pulses.
  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    bit_n   = bit_idx;
    sh_n    = shreg;
    data_n  = data;
    nd_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s == START_LVL) begin
          state_n = START_BIT;
          ctr_n   = '0;
          bit_n   = '0;
        end
      end
      START_BIT: begin
        if (ctr == HALF_M1) begin
          ctr_n   = '0;
          state_n = (rx_s == START_LVL) ? DATA : IDLE;
        end else begin
          ctr_n = ctr + CTR_SIZE'(1);
        end
      end
      DATA: begin
        if (ctr == FULL_M1) begin
          ctr_n         = '0;
          sh_n[bit_idx] = rx_s;
          bit_n         = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP_BIT;
          end
        end else begin
          ctr_n = ctr + CTR_SIZE'(1);
        end
      end
      STOP_BIT: begin
        if (ctr == FULL_M1) begin
          ctr_n = '0;
          if (rx_s == STOP_LVL) begin
            data_n  = shreg;
            nd_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = RECOVER;
          end
        end else begin
          ctr_n = ctr + CTR_SIZE'(1);
        end
      end
      RECOVER: begin
        if (rx_s == IDLE_LVL) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ctr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      ctr       <= ctr_n;
      bit_idx   <= bit_n;
      shreg     <= sh_n;
      data      <= data_n;
      new_data  <= nd_n;
      frame_err <= fe_n;
    end
  end

endmodule
